// File: rtl/axi_lite_gpio_irq_pkg.sv
// Shared register map and response encodings for the AXI-Lite GPIO block.
package axi_lite_gpio_irq_pkg;

    localparam int unsigned REG_IDX_W = 4;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_DATA_OUT = 4'd0;
    localparam reg_idx_t REG_DIR      = 4'd1;
    localparam reg_idx_t REG_DATA_IN  = 4'd2;
    localparam reg_idx_t REG_OUT_SET  = 4'd3;
    localparam reg_idx_t REG_OUT_CLR  = 4'd4;
    localparam reg_idx_t REG_OUT_TGL  = 4'd5;
    localparam reg_idx_t REG_RISE_EN  = 4'd6;
    localparam reg_idx_t REG_FALL_EN  = 4'd7;
    localparam reg_idx_t REG_STATUS   = 4'd8;
    localparam reg_idx_t REG_GIE      = 4'd9;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic is_mapped(input reg_idx_t idx);
        return idx <= REG_GIE;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-flop input synchroniser with a delayed copy for raw edge detection.
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise_raw,
    output logic [WIDTH-1:0] fall_raw
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  prev;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], gpio_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync     = chain[SYNC_STAGES-1];
    assign rise_raw = sync & ~prev;
    assign fall_raw = ~sync & prev;

endmodule

// File: rtl/axi_lite_gpio_irq.sv
// AXI4-Lite GPIO with direction, atomic SET/CLR/TGL, and edge interrupts with W1C status.
module axi_lite_gpio_irq
    import axi_lite_gpio_irq_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            GPIO_WIDTH  = 32,
    parameter int unsigned            SYNC_STAGES = 2,
    parameter logic [GPIO_WIDTH-1:0]  OUT_RESET   = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
    input  logic [2:0]              S_AXI_awprot,
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
    input  logic [2:0]              S_AXI_arprot,
    input  logic                    S_AXI_arvalid,
    output logic                    S_AXI_arready,
    output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
    output logic [1:0]              S_AXI_rresp,
    output logic                    S_AXI_rvalid,
    output logic                    S_AXI_rlast,
    input  logic                    S_AXI_rready,
    input  logic [GPIO_WIDTH-1:0]   gpio_in,
    output logic [GPIO_WIDTH-1:0]   gpio_out,
    output logic [GPIO_WIDTH-1:0]   gpio_oe,
    output logic                    irq
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);

    logic                  bus_rdy;
    logic                  aw_held, w_held;
    reg_idx_t              awidx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [GPIO_WIDTH-1:0] wmask, wval, w1c;

    logic [GPIO_WIDTH-1:0] data_out, dir, rise_en, fall_en, status;
    logic [GPIO_WIDTH-1:0] data_out_d, dir_d, rise_en_d, fall_en_d, status_d;
    logic                  gie, gie_d;
    logic [GPIO_WIDTH-1:0] sync, rise_raw, fall_raw;

    reg_idx_t              ridx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [1:0]            rd_resp;

    // Ready lines stay low until the first clock after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) bus_rdy <= 1'b0;
        else          bus_rdy <= 1'b1;
    end

    assign S_AXI_awready = bus_rdy & ~aw_held;
    assign S_AXI_wready  = bus_rdy & ~w_held;
    assign S_AXI_arready = bus_rdy & ~S_AXI_rvalid;
    assign S_AXI_rlast   = S_AXI_rvalid;

    assign aw_hs  = S_AXI_awvalid & S_AXI_awready;
    assign w_hs   = S_AXI_wvalid & S_AXI_wready;
    assign ar_hs  = S_AXI_arvalid & S_AXI_arready;
    assign commit = aw_held & w_held & ~S_AXI_bvalid;

    // AW and W are captured independently; the write commits once both are held and B is free.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            awidx_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            S_AXI_bvalid <= 1'b0;
            S_AXI_bresp  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                awidx_q <= S_AXI_awaddr[ADDR_LSB +: REG_IDX_W];
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_wdata;
                wstrb_q <= S_AXI_wstrb;
            end else if (commit) begin
                w_held <= 1'b0;
            end
            if (commit) begin
                S_AXI_bvalid <= 1'b1;
                S_AXI_bresp  <= is_mapped(awidx_q) ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_bvalid && S_AXI_bready) begin
                S_AXI_bvalid <= 1'b0;
            end
        end
    end

    for (genvar b = 0; b < STRB_W; b++) begin : g_lane
        assign lane_mask[b*8 +: 8] = {8{wstrb_q[b]}};
    end

    assign wmask = GPIO_WIDTH'(lane_mask);
    assign wval  = GPIO_WIDTH'(wdata_q) & wmask;

    gpio_sync_edge #(
        .WIDTH       (GPIO_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .gpio_in  (gpio_in),
        .sync     (sync),
        .rise_raw (rise_raw),
        .fall_raw (fall_raw)
    );

    // Register next-state; a new edge wins over a same-cycle W1C on the same bit.
    always_comb begin
        data_out_d = data_out;
        dir_d      = dir;
        rise_en_d  = rise_en;
        fall_en_d  = fall_en;
        gie_d      = gie;
        w1c        = '0;
        if (commit) begin
            case (awidx_q)
                REG_DATA_OUT: data_out_d = (data_out & ~wmask) | wval;
                REG_DIR:      dir_d      = (dir & ~wmask) | wval;
                REG_OUT_SET:  data_out_d = data_out | wval;
                REG_OUT_CLR:  data_out_d = data_out & ~wval;
                REG_OUT_TGL:  data_out_d = data_out ^ wval;
                REG_RISE_EN:  rise_en_d  = (rise_en & ~wmask) | wval;
                REG_FALL_EN:  fall_en_d  = (fall_en & ~wmask) | wval;
                REG_STATUS:   w1c        = wval;
                REG_GIE:      if (wstrb_q[0]) gie_d = wdata_q[0];
                default:      ;
            endcase
        end
        status_d = (status & ~w1c) | (rise_raw & rise_en) | (fall_raw & fall_en);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            data_out <= OUT_RESET;
            dir      <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            status   <= '0;
            gie      <= 1'b0;
            irq      <= 1'b0;
        end else begin
            data_out <= data_out_d;
            dir      <= dir_d;
            rise_en  <= rise_en_d;
            fall_en  <= fall_en_d;
            status   <= status_d;
            gie      <= gie_d;
            irq      <= gie & (|status);
        end
    end

    assign gpio_out = data_out;
    assign gpio_oe  = dir;

    assign ridx = S_AXI_araddr[ADDR_LSB +: REG_IDX_W];

    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        case (ridx)
            REG_DATA_OUT: rd_val = DATA_WIDTH'(data_out);
            REG_DIR:      rd_val = DATA_WIDTH'(dir);
            REG_DATA_IN:  rd_val = DATA_WIDTH'(sync);
            REG_OUT_SET, REG_OUT_CLR, REG_OUT_TGL: rd_val = '0;
            REG_RISE_EN:  rd_val = DATA_WIDTH'(rise_en);
            REG_FALL_EN:  rd_val = DATA_WIDTH'(fall_en);
            REG_STATUS:   rd_val = DATA_WIDTH'(status);
            REG_GIE:      rd_val = DATA_WIDTH'(gie);
            default:      rd_resp = RESP_SLVERR;
        endcase
    end

    // Single outstanding read; rdata holds until rready.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_rvalid <= 1'b0;
            S_AXI_rdata  <= '0;
            S_AXI_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_rvalid <= 1'b1;
            S_AXI_rdata  <= rd_val;
            S_AXI_rresp  <= rd_resp;
        end else if (S_AXI_rvalid && S_AXI_rready) begin
            S_AXI_rvalid <= 1'b0;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_awaddr, S_AXI_araddr,
                         wdata_q, lane_mask};

endmodule
